// File: rtl/fft_frame_pad.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_frame_pad : zero-pads WIN_LEN-sample windowed frames to N_FFT for the FFT.
// Rev 1.0 -- macro FFT_PAD_CENTER_EN selects centred padding (default: tail only).
// ---------------------------------------------------------------------------
module fft_frame_pad #(
    parameter int WIDTH      = 16,
    parameter int N_FFT      = 512,
    parameter int WIN_LEN    = 480,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        din_en,
    input  logic [WIDTH-1:0]            din_re,
    input  logic [WIDTH-1:0]            din_im,
    output logic                        dout_en,
    output logic [WIDTH-1:0]            dout_re,
    output logic [WIDTH-1:0]            dout_im,
    output logic                        dout_sop,
    output logic                        dout_eop,
    output logic                        ovf,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int PAD_TOT = N_FFT - WIN_LEN;
`ifdef FFT_PAD_CENTER_EN
    localparam int PAD_L   = PAD_TOT / 2;
`else
    localparam int PAD_L   = 0;
`endif
    localparam int PAD_R   = PAD_TOT - PAD_L;
    localparam int OW      = $clog2(N_FFT);
    localparam int DW      = $clog2(WIN_LEN);
    localparam int PW      = (PAD_TOT < 2) ? 1 : $clog2(PAD_TOT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_DATA = 2'd2,
        S_TAIL = 2'd3
    } state_t;

    state_t               state;
    logic [OW-1:0]        out_cnt;
    logic [DW-1:0]        dat_cnt;
    logic [PW-1:0]        pad_cnt;

    logic [2*WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [CW-1:0]        count_next;
    logic [2*WIDTH-1:0]   rd_data;

    assign full    = (fifo_count == CW'(FIFO_DEPTH));
    assign empty   = (fifo_count == '0);
    assign pop     = (state == S_DATA) && !empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign push    = din_en && (!full || pop);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CW'(1);
        end else if (!push && pop) begin
            count_next = fifo_count - CW'(1);
        end
    end

    function automatic state_t start_state();
        if (PAD_L > 0) begin
            return S_HEAD;
        end
        return S_DATA;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {din_re, din_im};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= count_next;
            if (din_en && !push) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            out_cnt  <= '0;
            dat_cnt  <= '0;
            pad_cnt  <= '0;
            dout_en  <= 1'b0;
            dout_re  <= '0;
            dout_im  <= '0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
        end else begin
            dout_en  <= 1'b0;
            dout_re  <= '0;
            dout_im  <= '0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            case (state)
                S_IDLE: begin
                    out_cnt <= '0;
                    if (!empty) begin
                        state <= start_state();
                    end
                end
                S_HEAD: begin
                    dout_en  <= 1'b1;
                    dout_sop <= (out_cnt == '0);
                    dout_eop <= (out_cnt == OW'(N_FFT - 1));
                    out_cnt  <= out_cnt + OW'(1);
                    if (pad_cnt == PW'(PAD_L - 1)) begin
                        pad_cnt <= '0;
                        state   <= S_DATA;
                    end else begin
                        pad_cnt <= pad_cnt + PW'(1);
                    end
                end
                S_DATA: begin
                    // An empty FIFO stalls the frame: bubble, counters hold.
                    if (!empty) begin
                        dout_en  <= 1'b1;
                        dout_re  <= rd_data[2*WIDTH-1:WIDTH];
                        dout_im  <= rd_data[WIDTH-1:0];
                        dout_sop <= (out_cnt == '0);
                        dout_eop <= (out_cnt == OW'(N_FFT - 1));
                        out_cnt  <= out_cnt + OW'(1);
                        if (dat_cnt == DW'(WIN_LEN - 1)) begin
                            dat_cnt <= '0;
                            if (PAD_R > 0) begin
                                state <= S_TAIL;
                            end else begin
                                out_cnt <= '0;
                                state   <= (count_next != '0) ? start_state() : S_IDLE;
                            end
                        end else begin
                            dat_cnt <= dat_cnt + DW'(1);
                        end
                    end
                end
                S_TAIL: begin
                    dout_en  <= 1'b1;
                    dout_sop <= (out_cnt == '0);
                    dout_eop <= (out_cnt == OW'(N_FFT - 1));
                    out_cnt  <= out_cnt + OW'(1);
                    if (pad_cnt == PW'(PAD_R - 1)) begin
                        // Chain straight into the next frame when data is waiting.
                        pad_cnt <= '0;
                        out_cnt <= '0;
                        state   <= (count_next != '0) ? start_state() : S_IDLE;
                    end else begin
                        pad_cnt <= pad_cnt + PW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_pad.sv
`default_nettype none
// tb_fft_frame_pad : randomized bench; a queue of expected padded frames is the model,
// plus an overflow instance (FIFO_DEPTH=16) checked against sticky/bound rules.
module tb_fft_frame_pad;

    localparam int W  = 16;
    localparam int N  = 512;
    localparam int WL = 480;
`ifdef FFT_PAD_CENTER_EN
    localparam int PL = (N - WL) / 2;
`else
    localparam int PL = 0;
`endif
    localparam int PR = N - WL - PL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_n, din_en, dout_en, dout_sop, dout_eop, ovf;
    logic [W-1:0] din_re, din_im, dout_re, dout_im;
    logic [6:0]   fifo_count;

    logic         rst_n2, din_en2, dout_en2, dout_sop2, dout_eop2, ovf2;
    logic [W-1:0] din_re2, din_im2, dout_re2, dout_im2;
    logic [4:0]   fifo_count2;

    fft_frame_pad #(.WIDTH(W), .N_FFT(N), .WIN_LEN(WL), .FIFO_DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .din_en(din_en), .din_re(din_re), .din_im(din_im),
        .dout_en(dout_en), .dout_re(dout_re), .dout_im(dout_im), .dout_sop(dout_sop),
        .dout_eop(dout_eop), .ovf(ovf), .fifo_count(fifo_count)
    );

    fft_frame_pad #(.WIDTH(W), .N_FFT(N), .WIN_LEN(WL), .FIFO_DEPTH(16)) dut_ovf (
        .clk(clk), .rst_n(rst_n2), .din_en(din_en2), .din_re(din_re2), .din_im(din_im2),
        .dout_en(dout_en2), .dout_re(dout_re2), .dout_im(dout_im2), .dout_sop(dout_sop2),
        .dout_eop(dout_eop2), .ovf(ovf2), .fifo_count(fifo_count2)
    );

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_q[$];
    int in_idx = 0, out_idx = 0, seen = 0, frame_len = 0;
    int drv_cyc = 0, lat_k = 0, last_eop = -1;
    bit lat_on = 1'b0, b2b_on = 1'b0;
    logic [W-1:0] got_re [N];
    logic [W-1:0] got_im [N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Each accepted input sample extends the expected stream; frame boundaries add pads.
    task automatic drive(input logic en, input logic [W-1:0] re, input logic [W-1:0] im);
        @(posedge clk);
        #2;
        drv_cyc = cyc;
        din_en  = en;
        din_re  = re;
        din_im  = im;
        if (en) begin
            if (in_idx == 0) repeat (PL) exp_q.push_back('0);
            exp_q.push_back({re, im});
            in_idx++;
            if (in_idx == WL) begin
                in_idx = 0;
                repeat (PR) exp_q.push_back('0);
            end
        end
    endtask

    task automatic drive2(input logic en, input logic [W-1:0] re, input logic [W-1:0] im);
        @(posedge clk);
        #2;
        din_en2 = en;
        din_re2 = re;
        din_im2 = im;
    endtask

    // mode 0: ramp re=i, im=-i; mode 1: random data. gap>0: idle after every gap samples,
    // gap<0: random idle cycles.
    task automatic send_frame(input int mode, input int gap, input int trail);
        logic [W-1:0] re, im;
        for (int i = 0; i < WL; i++) begin
            if (mode == 0) begin
                re = W'(i);
                im = W'(-i);
            end else begin
                re = W'($urandom);
                im = W'($urandom);
            end
            drive(1'b1, re, im);
            if (i == 0) lat_k = drv_cyc + 1;
            if (gap > 0 && (i % gap) == gap - 1) drive(1'b0, '0, '0);
            else if (gap < 0 && $urandom_range(0, 3) == 0) drive(1'b0, '0, '0);
        end
        repeat (trail) drive(1'b0, '0, '0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #2;
        chk("drain_fifo_count", fifo_count, 0);
    endtask

    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (rst_n) begin
            chk("main_ovf", ovf, 0);
            chk("main_fifo_bound", fifo_count <= 7'd64, 1);
            if (!dout_en) begin
                chk("sop_without_en", dout_sop, 0);
                chk("eop_without_en", dout_eop, 0);
            end else begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output actual=re %0h required=no output (t=%0t)", dout_re, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout_re", dout_re, e[2*W-1:W]);
                    chk("dout_im", dout_im, e[W-1:0]);
                    chk("dout_sop", dout_sop, out_idx == 0);
                    chk("dout_eop", dout_eop, out_idx == N - 1);
                    got_re[out_idx] = dout_re;
                    got_im[out_idx] = dout_im;
                    if (lat_on) chk("latency", cyc, lat_k + 2 + out_idx);
                    out_idx = (out_idx + 1) % N;
                end
                if (dout_sop) begin
                    if (b2b_on && last_eop >= 0) begin
                        chk("b2b_gap", cyc - last_eop, 1);
                        b2b_on = 1'b0;
                    end
                    seen = 0;
                end
                seen++;
                if (dout_eop) begin
                    frame_len = seen;
                    chk("frame_len", seen, N);
                    last_eop = cyc;
                end
            end
        end
    end

    int prev_cnt2 = 0, max_cnt2 = 0, seen2 = 0;
    bit prev_ovf2 = 1'b0, prev_din2 = 1'b0;

    always @(negedge clk) begin
        if (rst_n2) begin
            chk("ovf_fifo_bound", fifo_count2 <= 5'd16, 1);
            if (ovf2 && !prev_ovf2) chk("ovf_rise_on_full_push", (prev_cnt2 == 16) && prev_din2, 1);
            if (prev_ovf2) chk("ovf_sticky", ovf2, 1);
            if (int'(fifo_count2) > max_cnt2) max_cnt2 = int'(fifo_count2);
            if (dout_en2) begin
                if (dout_sop2) seen2 = 0;
                seen2++;
                if (dout_eop2) chk("ovf_inst_frame_len", seen2, N);
            end
        end
        prev_ovf2 = ovf2;
        prev_cnt2 = int'(fifo_count2);
        prev_din2 = din_en2;
    end

    initial begin
        rst_n = 1'b0; din_en = 1'b0; din_re = '0; din_im = '0;
        rst_n2 = 1'b0; din_en2 = 1'b0; din_re2 = '0; din_im2 = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        rst_n2 = 1'b1;
        @(negedge clk);
        chk("rst_dout_en", dout_en, 0);
        chk("rst_dout_re", dout_re, 0);
        chk("rst_dout_im", dout_im, 0);
        chk("rst_sop", dout_sop, 0);
        chk("rst_eop", dout_eop, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_ovf2", ovf2, 0);

        // Contiguous ramp frame with exact latency tracking.
        lat_on = 1'b1;
        send_frame(0, 0, 1);
        wait_drain();
        lat_on = 1'b0;
        chk("pin_re_479", got_re[PL + 479], 479);
        chk("pin_re_3", got_re[PL + 3], 3);
        chk("pin_im_m100", got_im[PL + 100], 16'hFF9C);
        chk("pin_tail_zero", got_re[N - 1], 0);
        chk("pin_frame_len", frame_len, 512);

        // Gapped input: bubbles in DATA, stream unchanged.
        send_frame(0, 10, 1);
        wait_drain();

        // Two frames separated by 160 idle cycles.
        send_frame(1, 0, 160);
        send_frame(1, 0, 1);
        wait_drain();

        // Nearly back-to-back frames: FIFO non-empty at frame end, no idle cycle.
        b2b_on = 1'b1;
        last_eop = -1;
        send_frame(1, 0, 1);
        send_frame(1, 0, 1);
        wait_drain();
        chk("b2b_observed", b2b_on, 0);

        repeat (2) send_frame(1, -1, 3);
        wait_drain();

        // Abort a frame around output sample 200 with an asynchronous reset.
        frame_len = 0;
        for (int i = 0; i < WL; i++) begin
            if (out_idx >= 200) break;
            drive(1'b1, W'(i), W'(-i));
        end
        din_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_dout_en", dout_en, 0);
        chk("abort_dout_re", dout_re, 0);
        chk("abort_sop", dout_sop, 0);
        chk("abort_eop", dout_eop, 0);
        chk("abort_fifo_count", fifo_count, 0);
        exp_q.delete();
        in_idx = 0;
        out_idx = 0;
        seen = 0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        send_frame(0, 0, 1);
        wait_drain();
        chk("post_reset_frame_len", frame_len, 512);

        // Overflow instance: three contiguous frames into a 16-deep FIFO.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < WL; i++) drive2(1'b1, W'($urandom), W'($urandom));
        end
        drive2(1'b0, '0, '0);
        repeat (700) @(posedge clk);
        #2;
        chk("ovf_final", ovf2, 1);
        chk("ovf_max_count", max_cnt2, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
